// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART pin bridge.
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        RD_SEND = 2'd2,
        REPLY   = 2'd3
    } state_t;

    localparam logic [7:0] ACK        = 8'h06;
    localparam logic [7:0] NAK        = 8'h15;
    localparam int         CMD_WR_BIT = 7;

    // Number of bytes that make up one port.
    function automatic int port_bytes(input int port_w);
        return port_w / 8;
    endfunction

    // Width of the port index; never less than one bit.
    function automatic int idx_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/uart_pin_bridge_pin_sync.sv
// Two-flop synchroniser for a bus of asynchronous inputs.
module pin_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;

    // Two register stages give metastability time to resolve.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r <= {W{1'b0}};
            q      <= {W{1'b0}};
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/uart_pin_bridge.sv
// UART command decoder giving a host read/write access to a bank of ports.
// Command byte: bit7 = write, bits[6:0] = port index. Data is LSB first.
module uart_pin_bridge
    import uart_bridge_pkg::*;
#(
    parameter int NUM_PORTS = 8,
    parameter int PORT_W    = 8,
    parameter int TIMEOUT   = 5000000
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_data,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    input  logic [NUM_PORTS*PORT_W-1:0] in_pins,
    output logic [NUM_PORTS*PORT_W-1:0] out_pins,
    output logic [NUM_PORTS-1:0]        out_strobe,
    output logic                        overrun
);

    localparam int PORT_BYTES = port_bytes(PORT_W);
    localparam int IDX_W      = idx_width(NUM_PORTS);
    localparam int BUS_W      = NUM_PORTS * PORT_W;
    localparam int TMO_W      = $clog2(TIMEOUT + 1);

    localparam logic [2:0]       LAST_CNT = 3'(PORT_BYTES);
    localparam logic [2:0]       LAST_RD  = 3'(PORT_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT - 1);
    localparam logic [7:0]       NUM_C    = 8'(NUM_PORTS);

    logic [BUS_W-1:0]  sync_pins_s;
    logic [PORT_W-1:0] in_ports_s  [NUM_PORTS];
    logic [PORT_W-1:0] out_ports_r [NUM_PORTS];

    state_t            state_r;
    logic [IDX_W-1:0]  idx_r;
    logic              idx_ok_r;
    logic [PORT_W-1:0] shadow_r;
    logic [PORT_W-1:0] snap_r;
    logic [2:0]        byte_cnt_r;
    logic [TMO_W-1:0]  tmo_r;

    logic [IDX_W-1:0]  rx_idx_s;
    logic              rx_idx_ok_s;
    logic [PORT_W-1:0] rx_ext_s;
    logic [PORT_W-1:0] shadow_next_s;
    logic [PORT_W-1:0] snap_next_s;
    logic              tx_fire_s;

    pin_sync #(.W(BUS_W)) u_pin_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (in_pins),
        .q     (sync_pins_s)
    );

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_ports
        assign in_ports_s[k]                  = sync_pins_s[k*PORT_W +: PORT_W];
        assign out_pins[k*PORT_W +: PORT_W]   = out_ports_r[k];
    end

    assign rx_idx_s      = rx_data[IDX_W-1:0];
    assign rx_idx_ok_s   = ({1'b0, rx_data[6:0]} < NUM_C);
    assign rx_ext_s      = PORT_W'(rx_data);
    // New bytes enter at the top so the first byte ends up least significant.
    assign shadow_next_s = (shadow_r >> 8) | (rx_ext_s << (PORT_W - 8));
    assign snap_next_s   = snap_r >> 8;
    assign tx_fire_s     = tx_valid & tx_ready;

    // Command FSM: decode, collect write data, stream read data, send replies.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r    <= IDLE;
            idx_r      <= {IDX_W{1'b0}};
            idx_ok_r   <= 1'b0;
            shadow_r   <= {PORT_W{1'b0}};
            snap_r     <= {PORT_W{1'b0}};
            byte_cnt_r <= 3'd0;
            tmo_r      <= {TMO_W{1'b0}};
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            overrun    <= 1'b0;
            out_strobe <= {NUM_PORTS{1'b0}};
            for (int k = 0; k < NUM_PORTS; k++) begin
                out_ports_r[k] <= {PORT_W{1'b0}};
            end
        end else begin
            out_strobe <= {NUM_PORTS{1'b0}};
            case (state_r)
                IDLE: begin
                    tmo_r <= {TMO_W{1'b0}};
                    if (rx_valid) begin
                        idx_r      <= rx_idx_s;
                        idx_ok_r   <= rx_idx_ok_s;
                        byte_cnt_r <= 3'd0;
                        if (rx_data[CMD_WR_BIT]) begin
                            state_r <= WR_DATA;
                        end else if (rx_idx_ok_s) begin
                            snap_r   <= in_ports_s[rx_idx_s];
                            tx_data  <= in_ports_s[rx_idx_s][7:0];
                            tx_valid <= 1'b1;
                            state_r  <= RD_SEND;
                        end else begin
                            tx_data  <= NAK;
                            tx_valid <= 1'b1;
                            state_r  <= REPLY;
                        end
                    end
                end
                WR_DATA: begin
                    if (byte_cnt_r == LAST_CNT) begin
                        // Commit cycle: whole port updates at once.
                        tmo_r <= {TMO_W{1'b0}};
                        if (rx_valid) begin
                            overrun <= 1'b1;
                        end
                        if (idx_ok_r) begin
                            out_ports_r[idx_r] <= shadow_r;
                            out_strobe         <= NUM_PORTS'(1'b1) << idx_r;
                            tx_data            <= ACK;
                        end else begin
                            tx_data <= NAK;
                        end
                        tx_valid <= 1'b1;
                        state_r  <= REPLY;
                    end else if (rx_valid) begin
                        shadow_r   <= shadow_next_s;
                        byte_cnt_r <= byte_cnt_r + 3'd1;
                        tmo_r      <= {TMO_W{1'b0}};
                    end else if (tmo_r == TMO_MAX) begin
                        tmo_r   <= {TMO_W{1'b0}};
                        state_r <= IDLE;
                    end else begin
                        tmo_r <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
                    end
                end
                RD_SEND: begin
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end
                    if (tx_fire_s) begin
                        if (byte_cnt_r == LAST_RD) begin
                            tx_valid <= 1'b0;
                            state_r  <= IDLE;
                        end else begin
                            snap_r     <= snap_next_s;
                            tx_data    <= snap_next_s[7:0];
                            byte_cnt_r <= byte_cnt_r + 3'd1;
                        end
                    end
                end
                REPLY: begin
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end
                    if (tx_fire_s) begin
                        tx_valid <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pin_bridge.sv
// Testbench for uart_pin_bridge: an 8x8 instance (a) and a 4x16 instance (b).
module tb_uart_pin_bridge;

    logic        sys_clk;
    logic        sys_rst_n;

    logic        a_rx_valid, b_rx_valid;
    logic [7:0]  a_rx_data,  b_rx_data;
    logic [7:0]  a_tx_data,  b_tx_data;
    logic        a_tx_valid, b_tx_valid;
    logic        a_tx_ready, b_tx_ready;
    logic [63:0] a_in_pins,  b_in_pins;
    logic [63:0] a_out_pins, b_out_pins;
    logic [7:0]  a_out_strobe;
    logic [3:0]  b_out_strobe;
    logic        a_overrun,  b_overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uart_pin_bridge #(.NUM_PORTS(8), .PORT_W(8), .TIMEOUT(1000)) dut_a (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .rx_valid   (a_rx_valid),
        .rx_data    (a_rx_data),
        .tx_data    (a_tx_data),
        .tx_valid   (a_tx_valid),
        .tx_ready   (a_tx_ready),
        .in_pins    (a_in_pins),
        .out_pins   (a_out_pins),
        .out_strobe (a_out_strobe),
        .overrun    (a_overrun)
    );

    uart_pin_bridge #(.NUM_PORTS(4), .PORT_W(16), .TIMEOUT(100)) dut_b (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .rx_valid   (b_rx_valid),
        .rx_data    (b_rx_data),
        .tx_data    (b_tx_data),
        .tx_valid   (b_tx_valid),
        .tx_ready   (b_tx_ready),
        .in_pins    (b_in_pins),
        .out_pins   (b_out_pins),
        .out_strobe (b_out_strobe),
        .overrun    (b_overrun)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit          wr;
        logic [7:0]  cmd;
        logic [7:0]  data;
        logic [63:0] pins;
        logic [7:0]  reply;
        logic [63:0] outs;
        logic [7:0]  strobe;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] b);
        if (sel) begin
            b_rx_valid = 1'b1;
            b_rx_data  = b;
        end else begin
            a_rx_valid = 1'b1;
            a_rx_data  = b;
        end
        tick();
        a_rx_valid = 1'b0;
        b_rx_valid = 1'b0;
    endtask

    // Wait (bounded) for a tx byte, then complete the handshake and compare.
    task automatic expect_tx(input bit sel, input string name, input logic [7:0] exp);
        logic [7:0] d;
        bit         ok;
        d  = 8'h00;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (sel ? b_tx_valid : a_tx_valid) begin
                d  = sel ? b_tx_data : a_tx_data;
                ok = 1'b1;
            end else begin
                tick();
            end
        end
        if (ok) begin
            if (sel) b_tx_ready = 1'b1; else a_tx_ready = 1'b1;
            tick();
            a_tx_ready = 1'b0;
            b_tx_ready = 1'b0;
        end
        check(name, {55'd0, ok, d}, {55'd0, 1'b1, exp});
    endtask

    initial begin
        logic [63:0] exp_out;
        int          seen;

        a_rx_valid = 1'b0; a_rx_data = 8'h00; a_tx_ready = 1'b0; a_in_pins = 64'd0;
        b_rx_valid = 1'b0; b_rx_data = 8'h00; b_tx_ready = 1'b0; b_in_pins = 64'd0;

        //          wr    cmd    data   pins                    reply  outs                    strobe
        vecs[0] = '{1'b1, 8'h82, 8'h5A, 64'h0,                  8'h06, 64'h0000_0000_005A_0000, 8'h04};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 64'h0000_0000_0000_000F, 8'h0F, 64'h0000_0000_005A_0000, 8'h00};
        vecs[2] = '{1'b1, 8'h87, 8'hC3, 64'h0,                  8'h06, 64'hC300_0000_005A_0000, 8'h80};
        vecs[3] = '{1'b0, 8'h09, 8'h00, 64'h0,                  8'h15, 64'hC300_0000_005A_0000, 8'h00};
        vecs[4] = '{1'b1, 8'h89, 8'hAA, 64'h0,                  8'h15, 64'hC300_0000_005A_0000, 8'h00};
        vecs[5] = '{1'b0, 8'h05, 8'h00, 64'h0000_AB00_0000_0000, 8'hAB, 64'hC300_0000_005A_0000, 8'h00};
        vecs[6] = '{1'b1, 8'h80, 8'hFF, 64'h0,                  8'h06, 64'hC300_0000_005A_00FF, 8'h01};

        sys_rst_n = 1'b0;
        repeat (3) tick();
        sys_rst_n = 1'b1;
        tick();

        check("rst_a_out",     a_out_pins,   64'd0);
        check("rst_a_strobe",  a_out_strobe, 64'd0);
        check("rst_a_txv",     a_tx_valid,   64'd0);
        check("rst_a_txd",     a_tx_data,    64'd0);
        check("rst_a_overrun", a_overrun,    64'd0);
        check("rst_b_out",     b_out_pins,   64'd0);
        check("rst_b_txv",     b_tx_valid,   64'd0);

        // Table-driven single-byte-port transactions on instance a.
        exp_out = 64'd0;
        for (int i = 0; i < 7; i++) begin
            a_in_pins = vecs[i].pins;
            repeat (3) tick();
            send(1'b0, vecs[i].cmd);
            if (vecs[i].wr) begin
                send(1'b0, vecs[i].data);
                check("wr_pre_commit_out", a_out_pins, exp_out);
                tick();
                check("wr_strobe", a_out_strobe, vecs[i].strobe);
                check("wr_out",    a_out_pins,   vecs[i].outs);
            end else begin
                check("rd_first_byte_latency", a_tx_valid, 64'd1);
            end
            expect_tx(1'b0, "reply", vecs[i].reply);
            repeat (3) tick();
            check("no_extra_tx",   a_tx_valid,   64'd0);
            check("strobe_idle",   a_out_strobe, 64'd0);
            check("out_unchanged", a_out_pins,   vecs[i].outs);
            exp_out = vecs[i].outs;
        end

        // Multi-byte write to port 1 of instance b.
        send(1'b1, 8'h81);
        send(1'b1, 8'h34);
        send(1'b1, 8'h12);
        check("mb_pre_commit", b_out_pins, 64'd0);
        tick();
        check("mb_out",    b_out_pins,   64'h0000_0000_1234_0000);
        check("mb_strobe", b_out_strobe, 64'h2);
        expect_tx(1'b1, "mb_ack", 8'h06);

        // Read port 1; inputs change after the command, reply must come from the snapshot.
        b_in_pins = 64'h0000_0000_BEEF_0000;
        repeat (3) tick();
        send(1'b1, 8'h01);
        b_in_pins = 64'h0000_0000_1111_0000;
        expect_tx(1'b1, "snap_lo", 8'hEF);
        expect_tx(1'b1, "snap_hi", 8'hBE);
        repeat (3) tick();
        check("snap_no_extra", b_tx_valid, 64'd0);

        // Gap just under the timeout keeps the frame alive.
        send(1'b1, 8'h80);
        send(1'b1, 8'h11);
        repeat (95) tick();
        send(1'b1, 8'h22);
        tick();
        check("gap_out",    b_out_pins,   64'h0000_0000_1234_2211);
        check("gap_strobe", b_out_strobe, 64'h1);
        expect_tx(1'b1, "gap_ack", 8'h06);

        // Gap beyond the timeout discards the frame silently.
        send(1'b1, 8'h80);
        send(1'b1, 8'h33);
        seen = 0;
        for (int i = 0; i < 110; i++) begin
            tick();
            if (b_tx_valid) seen++;
        end
        check("tmo_no_reply", seen, 64'd0);
        check("tmo_out",      b_out_pins, 64'h0000_0000_1234_2211);
        b_in_pins = 64'h0000_0000_0000_5678;
        repeat (3) tick();
        send(1'b1, 8'h00);
        expect_tx(1'b1, "tmo_rd_lo", 8'h78);
        expect_tx(1'b1, "tmo_rd_hi", 8'h56);

        // Reset in the middle of a write frame.
        send(1'b1, 8'h80);
        send(1'b1, 8'h44);
        sys_rst_n = 1'b0;
        repeat (2) tick();
        sys_rst_n = 1'b1;
        check("mrst_b_out", b_out_pins, 64'd0);
        check("mrst_a_out", a_out_pins, 64'd0);
        check("mrst_txv",   b_tx_valid, 64'd0);
        repeat (3) tick();
        send(1'b1, 8'h00);
        expect_tx(1'b1, "mrst_rd_lo", 8'h78);
        expect_tx(1'b1, "mrst_rd_hi", 8'h56);

        // Byte arriving while a read is stalled sets the sticky overrun flag.
        check("ovr_clear", b_overrun, 64'd0);
        b_in_pins = 64'h0000_A5C3_0000_0000;
        repeat (3) tick();
        send(1'b1, 8'h02);
        send(1'b1, 8'h55);
        tick();
        check("ovr_set",  b_overrun, 64'd1);
        check("ovr_hold", {b_tx_valid, b_tx_data}, 64'h1C3);
        expect_tx(1'b1, "ovr_rd_lo", 8'hC3);
        expect_tx(1'b1, "ovr_rd_hi", 8'hA5);
        repeat (5) tick();
        check("ovr_sticky", b_overrun,  64'd1);
        check("ovr_idle",   b_tx_valid, 64'd0);
        check("a_no_ovr",   a_overrun,  64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
